// File: rtl/program_counter.sv
// Fetch-stage program counter: holds the fetch address and selects the next one from
// sequential, PC-relative branch, JAL or JALR sources. It stalls while the L1 I-cache is busy.
module program_counter #(
    parameter int unsigned pc_size = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               L1_busy,
    input  logic               branch_instruction,
    input  logic [1:0]         pc_select,
    input  logic [pc_size-1:0] alu_result,
    input  logic [pc_size-1:0] jal_address,
    output logic [pc_size-1:0] pc_next,
    output logic [pc_size-1:0] pc_plus_four_next
);

    localparam logic [pc_size-1:0] PcStep = pc_size'(4);

    typedef enum logic [1:0] {
        SelSeq    = 2'd0,
        SelBranch = 2'd1,
        SelJal    = 2'd2,
        SelJalr   = 2'd3
    } pc_sel_e;

    logic [pc_size-1:0] pc_q;
    logic [pc_size-1:0] pc_d;
    logic [pc_size-1:0] pc_plus_four;
    logic [pc_size-1:0] jalr_target;
    pc_sel_e            sel;

    // Taken/not-taken is already folded into pc_select, so this status input stays unused.
    logic unused_branch;
    assign unused_branch = branch_instruction;

    assign sel          = pc_sel_e'(pc_select);
    assign pc_plus_four = pc_q + PcStep;
    assign jalr_target  = {alu_result[pc_size-1:1], 1'b0};

    always_comb begin
        pc_d = pc_q;
        if (!L1_busy) begin
            unique case (sel)
                SelSeq:    pc_d = pc_plus_four;
                SelBranch: pc_d = pc_q + alu_result;
                SelJal:    pc_d = jal_address;
                SelJalr:   pc_d = jalr_target;
                default:   pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_next           = pc_q;
    assign pc_plus_four_next = pc_plus_four;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus randomized traffic
// checked against a behavioural next-PC model.
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic        L1_busy;
    logic        branch_instruction;
    logic [1:0]  pc_select;
    logic [31:0] alu_result;
    logic [31:0] jal_address;
    logic [31:0] pc_next;
    logic [31:0] pc_plus_four_next;

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          clk_run = 0;
    logic [31:0] model_pc = '0;

    program_counter #(.pc_size(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .L1_busy            (L1_busy),
        .branch_instruction (branch_instruction),
        .pc_select          (pc_select),
        .alu_result         (alu_result),
        .jal_address        (jal_address),
        .pc_next            (pc_next),
        .pc_plus_four_next  (pc_plus_four_next)
    );

    initial begin
        clk = 0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    // Next fetch address from the architectural rules, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic busy,
                                             input int sel, input logic [31:0] alu,
                                             input logic [31:0] jal);
        if (busy) return pc;
        if (sel == 0) return pc + 32'd4;
        if (sel == 1) return pc + alu;
        if (sel == 2) return jal;
        return alu - (alu % 32'd2);
    endfunction

    task automatic drive(input logic busy, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] jal);
        L1_busy     = busy;
        pc_select   = sel;
        alu_result  = alu;
        jal_address = jal;
        @(posedge clk);
        #1;
        model_pc = ref_next(model_pc, busy, int'(sel), alu, jal);
    endtask

    task automatic test_reset;
        reset = 1; L1_busy = 1; branch_instruction = 0;
        pc_select = 0; alu_result = 0; jal_address = 0;
        #2 reset = 0;
        #2;
        total++;
        if (pc_next !== 32'd0) begin
            bad++; $display("FAIL reset_pc: got %h want %h", pc_next, 32'd0);
        end
        total++;
        if (pc_plus_four_next !== 32'd4) begin
            bad++; $display("FAIL reset_plus4: got %h want %h", pc_plus_four_next, 32'd4);
        end
        #2 reset = 1;
        model_pc = 0;
        clk_run = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd2, $urandom, $urandom);
            total++;
            if (pc_next !== 32'd0) begin
                bad++; $display("FAIL reset_busy_hold%0d: got %h want %h", i, pc_next, 32'd0);
            end
        end
    endtask

    task automatic test_sequential;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 2'd0, $urandom, $urandom);
            total++;
            if (pc_next !== 32'(4 * i)) begin
                bad++; $display("FAIL seq%0d: got %h want %h", i, pc_next, 32'(4 * i));
            end
            total++;
            if (pc_plus_four_next !== 32'(4 * i + 4)) begin
                bad++; $display("FAIL seq_plus4_%0d: got %h want %h", i, pc_plus_four_next,
                                32'(4 * i + 4));
            end
        end
    endtask

    task automatic test_branch;
        drive(1'b0, 2'd1, 32'd36, $urandom);
        total++;
        if (pc_next !== 32'd52) begin
            bad++; $display("FAIL branch_fwd: got %h want %h", pc_next, 32'd52);
        end
        drive(1'b0, 2'd1, 32'hFFFF_FFF8, $urandom);
        total++;
        if (pc_next !== 32'd44) begin
            bad++; $display("FAIL branch_back: got %h want %h", pc_next, 32'd44);
        end
    endtask

    task automatic test_jal_jalr;
        drive(1'b0, 2'd2, $urandom, 32'd120);
        total++;
        if (pc_next !== 32'd120) begin
            bad++; $display("FAIL jal: got %h want %h", pc_next, 32'd120);
        end
        total++;
        if (pc_plus_four_next !== 32'd124) begin
            bad++; $display("FAIL jal_plus4: got %h want %h", pc_plus_four_next, 32'd124);
        end
        drive(1'b0, 2'd3, 32'hFFFF_FFF3, $urandom);
        total++;
        if (pc_next !== 32'hFFFF_FFF2) begin
            bad++; $display("FAIL jalr: got %h want %h", pc_next, 32'hFFFF_FFF2);
        end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'd2, $urandom, 32'd200);
            total++;
            if (pc_next !== 32'hFFFF_FFF2) begin
                bad++; $display("FAIL stall%0d: got %h want %h", i, pc_next, 32'hFFFF_FFF2);
            end
        end
        drive(1'b0, 2'd2, $urandom, 32'd200);
        total++;
        if (pc_next !== 32'd200) begin
            bad++; $display("FAIL stall_release: got %h want %h", pc_next, 32'd200);
        end
    endtask

    task automatic test_wrap_reset;
        drive(1'b0, 2'd2, $urandom, 32'hFFFF_FFFC);
        total++;
        if (pc_plus_four_next !== 32'd0) begin
            bad++; $display("FAIL wrap_plus4: got %h want %h", pc_plus_four_next, 32'd0);
        end
        drive(1'b0, 2'd0, $urandom, $urandom);
        total++;
        if (pc_next !== 32'd0) begin
            bad++; $display("FAIL wrap_seq: got %h want %h", pc_next, 32'd0);
        end
        drive(1'b0, 2'd0, $urandom, $urandom);
        drive(1'b0, 2'd0, $urandom, $urandom);
        total++;
        if (pc_next !== 32'd8) begin
            bad++; $display("FAIL pre_reset: got %h want %h", pc_next, 32'd8);
        end
        #2 reset = 0;
        #1;
        model_pc = 0;
        total++;
        if (pc_next !== 32'd0) begin
            bad++; $display("FAIL midop_reset: got %h want %h", pc_next, 32'd0);
        end
        @(posedge clk);
        #1;
        total++;
        if (pc_next !== 32'd0) begin
            bad++; $display("FAIL reset_held_edge: got %h want %h", pc_next, 32'd0);
        end
        @(negedge clk);
        reset = 1;
        #1;
        for (int i = 1; i <= 2; i++) begin
            drive(1'b0, 2'd0, $urandom, $urandom);
            total++;
            if (pc_next !== 32'(4 * i)) begin
                bad++; $display("FAIL post_reset%0d: got %h want %h", i, pc_next, 32'(4 * i));
            end
        end
    endtask

    task automatic test_random;
        logic        busy;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] jal;
        for (int i = 0; i < 300; i++) begin
            busy = ($urandom_range(0, 3) == 0);
            sel  = 2'($urandom_range(0, 3));
            alu  = $urandom;
            jal  = $urandom;
            branch_instruction = ($urandom_range(0, 4) == 0) ? 1'bx : 1'($urandom_range(0, 1));
            drive(busy, sel, alu, jal);
            total++;
            if (pc_next !== model_pc) begin
                bad++; $display("FAIL rand_pc%0d: got %h want %h", i, pc_next, model_pc);
            end
            total++;
            if (pc_plus_four_next !== model_pc + 32'd4) begin
                bad++; $display("FAIL rand_plus4_%0d: got %h want %h", i, pc_plus_four_next,
                                model_pc + 32'd4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jal_jalr();
        test_stall();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
